// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths and ALU function codes for the MIPS datapath primitives
package mips_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_NOR  = 4'b0100,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_SRL  = 4'b1001,
    ALU_SRA  = 4'b1010,
    ALU_SLTU = 4'b1011,
    ALU_LUI  = 4'b1100
  } alu_op_e;

endpackage

// File: rtl/mips_regfile.sv
// rtl/mips_regfile.sv - 32x32 register file with hardwired r0 and write-through read bypass
module mips_regfile
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  input  logic [AW-1:0]   wa,
  input  logic            we,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [NREG];
  logic            wr_ok;
  logic            byp1;
  logic            byp2;

  assign wr_ok = we && (wa != '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wa] <= wd;
    end
  end

  // Bypass lets decode see the value write-back commits on the coming edge; a reset edge discards it.
  assign byp1 = reset_n && wr_ok && (wa == ra1);
  assign byp2 = reset_n && wr_ok && (wa == ra2);

  assign rd1 = (ra1 == '0) ? '0 : (byp1 ? wd : regs[ra1]);
  assign rd2 = (ra2 == '0) ? '0 : (byp2 ? wd : regs[ra2]);

endmodule

// File: rtl/alu_regfile_signex.sv
// rtl/alu_regfile_signex.sv - register file, immediate sign extender and combinational ALU side by side
module alu_regfile_signex
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  input  logic [AW-1:0]   wa,
  input  logic            we,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic [15:0]     imm_in,
  output logic [XLEN-1:0] imm_out,
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  input  logic [3:0]      alu_f,
  output logic [XLEN-1:0] alu_y,
  output logic            alu_zf
);

  logic [4:0] sa;

  mips_regfile u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .ra1     (ra1),
    .ra2     (ra2),
    .wa      (wa),
    .we      (we),
    .wd      (wd),
    .rd1     (rd1),
    .rd2     (rd2)
  );

  assign imm_out = {{(XLEN-16){imm_in[15]}}, imm_in};

  assign sa = alu_a[4:0];

  always_comb begin
    alu_y = '0;
    case (alu_f)
      ALU_AND:  alu_y = alu_a & alu_b;
      ALU_OR:   alu_y = alu_a | alu_b;
      ALU_ADD:  alu_y = alu_a + alu_b;
      ALU_XOR:  alu_y = alu_a ^ alu_b;
      ALU_NOR:  alu_y = ~(alu_a | alu_b);
      ALU_SUB:  alu_y = alu_a - alu_b;
      ALU_SLT:  alu_y = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      ALU_SLL:  alu_y = alu_b << sa;
      ALU_SRL:  alu_y = alu_b >> sa;
      ALU_SRA:  alu_y = $signed(alu_b) >>> sa;
      ALU_SLTU: alu_y = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
      ALU_LUI:  alu_y = {alu_b[15:0], 16'h0000};
      default:  alu_y = '0;
    endcase
  end

  assign alu_zf = (alu_y == '0);

endmodule

// File: tb/tb_alu_regfile_signex.sv
// tb/tb_alu_regfile_signex.sv - randomized self-checking bench against a behavioural model
module tb_alu_regfile_signex;

  logic        clk;
  logic        reset_n;
  logic [4:0]  ra1, ra2, wa;
  logic        we;
  logic [31:0] wd, rd1, rd2;
  logic [15:0] imm_in;
  logic [31:0] imm_out;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_f;
  logic        alu_zf;

  int passed = 0;
  int total  = 0;
  logic [31:0] model [32];

  alu_regfile_signex dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ra1     (ra1),
    .ra2     (ra2),
    .wa      (wa),
    .we      (we),
    .wd      (wd),
    .rd1     (rd1),
    .rd2     (rd2),
    .imm_in  (imm_in),
    .imm_out (imm_out),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_f   (alu_f),
    .alu_y   (alu_y),
    .alu_zf  (alu_zf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else passed++;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] addr);
    if (addr == 0) return 32'h0;
    if (reset_n && we && wa == addr) return wd;
    return model[addr];
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub, p;
    longint sa_s, sb_s;
    int sh;
    ua = a; ub = b;
    sa_s = $signed(a); sb_s = $signed(b);
    sh = a % 32;
    p = 64'd1 << sh;
    case (f)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return 32'((ua + ub) % 64'h1_0000_0000);
      4'd3:  return a ^ b;
      4'd4:  return ~(a | b);
      4'd6:  return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
      4'd7:  return (sa_s < sb_s) ? 32'd1 : 32'd0;
      4'd8:  return 32'((ub * p) % 64'h1_0000_0000);
      4'd9:  return 32'(ub / p);
      4'd10: return 32'(ub / p) | (b[31] ? ~32'(64'hFFFF_FFFF / p) : 32'h0);
      4'd11: return (ua < ub) ? 32'd1 : 32'd0;
      4'd12: return 32'((ub % 65536) * 65536);
      default: return 32'h0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    if (!reset_n) for (int i = 0; i < 32; i++) model[i] = 32'h0;
    else if (we && wa != 0) model[wa] = wd;
    #1;
  endtask

  task automatic alu_case(input string tag, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    alu_f = f; alu_a = a; alu_b = b;
    #1;
    check(tag, alu_y, exp);
    check({tag, "_zf"}, {31'h0, alu_zf}, {31'h0, exp == 0});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = $urandom;
    reset_n = 1'b0; we = 1'b1; wa = 5'd3; wd = 32'hCAFEF00D;
    ra1 = 0; ra2 = 0; imm_in = 0; alu_a = 0; alu_b = 0; alu_f = 0;
    #2;
    check("zero_alu", alu_y, 32'h0);
    check("zero_zf", {31'h0, alu_zf}, 32'h1);
    check("zero_imm", imm_out, 32'h0);
    step();
    reset_n = 1'b1; we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      check($sformatf("rst_rd1_%0d", i), rd1, 32'h0);
      check($sformatf("rst_rd2_%0d", 31 - i), rd2, 32'h0);
    end

    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra1 = 5'd5;
    step();
    we = 1'b0;
    #1 check("r5_read", rd1, 32'hDEADBEEF);
    we = 1'b1; wa = 5'd0; wd = 32'h12345678; ra2 = 5'd0;
    #1 check("r0_bypass", rd2, 32'h0);
    step();
    we = 1'b0;
    #1 check("r0_read", rd2, 32'h0);

    we = 1'b1; wa = 5'd9; wd = 32'h11112222;
    step();
    ra1 = 5'd9; ra2 = 5'd9; wa = 5'd9; we = 1'b1; wd = 32'hA5A5A5A5;
    #1;
    check("byp_rd1", rd1, 32'hA5A5A5A5);
    check("byp_rd2", rd2, 32'hA5A5A5A5);
    we = 1'b0;
    #1;
    check("nobyp_rd1", rd1, 32'h11112222);
    check("nobyp_rd2", rd2, 32'h11112222);

    // Mid-sequence reset: the bypass must be suppressed and the pending write dropped.
    reset_n = 1'b0; we = 1'b1; wd = 32'h77778888;
    #1 check("rst_byp_off", rd1, 32'h11112222);
    step();
    reset_n = 1'b1; we = 1'b0;
    #1 check("rst_clear_r9", rd1, 32'h0);
    ra1 = 5'd5;
    #1 check("rst_clear_r5", rd1, 32'h0);

    imm_in = 16'h8000; #1 check("sext_neg", imm_out, 32'hFFFF8000);
    imm_in = 16'h7FFF; #1 check("sext_pos", imm_out, 32'h00007FFF);

    alu_case("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h1, 32'h0);
    alu_case("sub", 4'b0110, 32'd5, 32'd7, 32'hFFFFFFFE);
    alu_case("slt", 4'b0111, 32'hFFFFFFFF, 32'h1, 32'h1);
    alu_case("sltu", 4'b1011, 32'hFFFFFFFF, 32'h1, 32'h0);
    alu_case("nor", 4'b0100, 32'h0, 32'h0, 32'hFFFFFFFF);
    alu_case("sll", 4'b1000, 32'd4, 32'h80000010, 32'h00000100);
    alu_case("srl", 4'b1001, 32'd4, 32'h80000010, 32'h08000001);
    alu_case("sra", 4'b1010, 32'd4, 32'h80000010, 32'hF8000001);
    alu_case("lui", 4'b1100, 32'h0, 32'h1234, 32'h12340000);
    alu_case("undef", 4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);

    for (int n = 0; n < 400; n++) begin
      reset_n = ($urandom_range(0, 39) != 0);
      we = $urandom_range(0, 1);
      wa = 5'($urandom); wd = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      imm_in = 16'($urandom);
      alu_f = 4'($urandom);
      alu_a = $urandom;
      alu_b = ($urandom_range(0, 5) == 0) ? alu_a : $urandom;
      if ($urandom_range(0, 2) == 0) alu_a = $urandom_range(0, 40);
      #1;
      check("rnd_rd1", rd1, exp_read(ra1));
      check("rnd_rd2", rd2, exp_read(ra2));
      check("rnd_imm", imm_out, {{16{imm_in[15]}}, imm_in});
      check($sformatf("rnd_alu_f%0d", alu_f), alu_y, ref_alu(alu_f, alu_a, alu_b));
      check("rnd_zf", {31'h0, alu_zf}, {31'h0, ref_alu(alu_f, alu_a, alu_b) == 0});
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
